// File: rtl/drive_actuator.sv
// Drive-train plant model: rate-limited speed ramps on a divided tick plus a door-lock interlock.
// Optional OVERSPEED_FLAG_EN adds a runtime speed_limit input and a registered overspeed flag.
module drive_actuator #(
    parameter int unsigned SPEED_W   = 8,
    parameter int unsigned MAX_SPEED = 200,
    parameter int unsigned ACC_STEP  = 2,
    parameter int unsigned DEC_STEP  = 4,
    parameter int unsigned TICK_DIV  = 10,
    parameter int unsigned DOOR_HOLD = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               accelerate_car,
    input  logic               unlock_doors,
`ifdef OVERSPEED_FLAG_EN
    input  logic [SPEED_W-1:0] speed_limit,
    output logic               overspeed,
`endif
    output logic [SPEED_W-1:0] car_speed,
    output logic               doors_unlocked,
    output logic               moving,
    output logic [1:0]         drv_state
);

    localparam int unsigned CntW  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned HoldW = (DOOR_HOLD > 1) ? $clog2(DOOR_HOLD + 1) : 1;

    typedef enum logic [1:0] {
        StParked = 2'b00,
        StAccel  = 2'b01,
        StHold   = 2'b10,
        StBrake  = 2'b11
    } state_e;

    state_e              state;
    logic [CntW-1:0]     tick_cnt;
    logic [HoldW-1:0]    hold_cnt;
    logic                tick;
    logic [SPEED_W:0]    ceil_w;
    logic [SPEED_W:0]    sum_w;
    logic                at_ceil;
    logic [SPEED_W-1:0]  acc_speed;
    logic [SPEED_W-1:0]  dec_speed;
    logic [SPEED_W-1:0]  speed_nxt;

    assign drv_state = state;

    always_comb begin
        tick = enable && (tick_cnt == CntW'(TICK_DIV - 1));

`ifdef OVERSPEED_FLAG_EN
        ceil_w = ({1'b0, speed_limit} < (SPEED_W + 1)'(MAX_SPEED)) ? {1'b0, speed_limit}
                                                                   : (SPEED_W + 1)'(MAX_SPEED);
`else
        ceil_w = (SPEED_W + 1)'(MAX_SPEED);
`endif
        sum_w   = {1'b0, car_speed} + (SPEED_W + 1)'(ACC_STEP);
        // >= so a speed already above a lowered limit is held, never pulled down by ACCEL
        at_ceil = {1'b0, car_speed} >= ceil_w;

        if (at_ceil) begin
            acc_speed = car_speed;
        end else if (sum_w > ceil_w) begin
            acc_speed = ceil_w[SPEED_W-1:0];
        end else begin
            acc_speed = sum_w[SPEED_W-1:0];
        end

        if ({1'b0, car_speed} > (SPEED_W + 1)'(DEC_STEP)) begin
            dec_speed = car_speed - SPEED_W'(DEC_STEP);
        end else begin
            dec_speed = '0;
        end

        speed_nxt = car_speed;
        if (tick) begin
            unique case (state)
                StParked: speed_nxt = '0;
                StAccel:  speed_nxt = acc_speed;
                StBrake:  speed_nxt = dec_speed;
                default:  speed_nxt = car_speed;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= StParked;
            tick_cnt       <= '0;
            hold_cnt       <= '0;
            car_speed      <= '0;
            moving         <= 1'b0;
            doors_unlocked <= 1'b0;
`ifdef OVERSPEED_FLAG_EN
            overspeed      <= 1'b0;
`endif
        end else begin
            if (enable) begin
                tick_cnt <= (tick_cnt == CntW'(TICK_DIV - 1)) ? '0 : tick_cnt + 1'b1;
            end

            car_speed <= speed_nxt;
            moving    <= (speed_nxt != '0);
`ifdef OVERSPEED_FLAG_EN
            overspeed <= (speed_nxt > speed_limit);
`endif

            unique case (state)
                StParked: begin
                    if (accelerate_car && !unlock_doors && !doors_unlocked) state <= StAccel;
                end
                StAccel: begin
                    if (!accelerate_car || unlock_doors) state <= StBrake;
                    else if (at_ceil)                    state <= StHold;
                end
                StHold: begin
                    if (!accelerate_car || unlock_doors) state <= StBrake;
                end
                StBrake: begin
                    if (car_speed == '0)                        state <= StParked;
                    else if (accelerate_car && !unlock_doors)   state <= StAccel;
                end
                default: state <= StParked;
            endcase

            if (state != StParked || !unlock_doors) begin
                hold_cnt <= '0;
            end else if (tick && hold_cnt < HoldW'(DOOR_HOLD)) begin
                hold_cnt <= hold_cnt + 1'b1;
            end

            // Unlock only from a settled PARKED state; any drop of the request relocks at once
            if (!unlock_doors) begin
                doors_unlocked <= 1'b0;
            end else if (state == StParked && hold_cnt == HoldW'(DOOR_HOLD) && !moving) begin
                doors_unlocked <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_drive_actuator.sv
// Directed self-checking bench for drive_actuator with default parameters.
// Edge numbers in comments count rising edges since reset release (ticks on multiples of 10).
module tb_drive_actuator;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       accelerate_car;
    logic       unlock_doors;
    logic [7:0] car_speed;
    logic       doors_unlocked;
    logic       moving;
    logic [1:0] drv_state;
`ifdef OVERSPEED_FLAG_EN
    logic [7:0] speed_limit;
    logic       overspeed;
`endif

    int n_cmp = 0;
    int n_err = 0;

    drive_actuator dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .accelerate_car (accelerate_car),
        .unlock_doors   (unlock_doors),
`ifdef OVERSPEED_FLAG_EN
        .speed_limit    (speed_limit),
        .overspeed      (overspeed),
`endif
        .car_speed      (car_speed),
        .doors_unlocked (doors_unlocked),
        .moving         (moving),
        .drv_state      (drv_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n          = 1'b0;
        enable         = 1'b1;
        accelerate_car = 1'b0;
        unlock_doors   = 1'b0;
`ifdef OVERSPEED_FLAG_EN
        speed_limit    = 8'd255;
`endif
        repeat (3) @(negedge clk);
        check("rst_speed", car_speed, 0);
        check("rst_state", drv_state, 0);
        check("rst_doors", doors_unlocked, 0);
        check("rst_moving", moving, 0);

        rst_n = 1'b1;
        accelerate_car = 1'b1;
        step(1);    // e1
        check("accel_state", drv_state, 1);
        check("accel_speed0", car_speed, 0);
        step(9);    // e10
        check("tick1_speed", car_speed, 2);
        step(10);   // e20
        check("tick2_speed", car_speed, 4);
        step(10);   // e30
        check("tick3_speed", car_speed, 6);
        step(970);  // e1000
        check("max_speed", car_speed, 200);
        check("max_state_accel", drv_state, 1);
        step(1);    // e1001
        check("hold_state", drv_state, 2);
        check("hold_moving", moving, 1);

        accelerate_car = 1'b0;
        step(1);    // e1002
        check("brake_state", drv_state, 3);
        step(8);    // e1010
        check("brake_tick1", car_speed, 196);
        step(490);  // e1500
        check("brake_zero", car_speed, 0);
        check("brake_moving0", moving, 0);
        check("brake_state_at0", drv_state, 3);
        step(1);    // e1501
        check("parked_again", drv_state, 0);

        accelerate_car = 1'b1;
        step(1);    // e1502
        check("reaccel_state", drv_state, 1);
        step(98);   // e1600
        check("speed_20", car_speed, 20);
        unlock_doors = 1'b1;
        step(1);    // e1601
        check("unlock_brake", drv_state, 3);
        check("doors_moving", doors_unlocked, 0);
        step(49);   // e1650
        check("unlock_stop", car_speed, 0);
        check("doors_at_stop", doors_unlocked, 0);
        step(1);    // e1651
        check("unlock_parked", drv_state, 0);
        step(29);   // e1680, hold counter reaches 3 here
        check("doors_early", doors_unlocked, 0);
        step(1);    // e1681
        check("doors_open", doors_unlocked, 1);
        check("doors_block", drv_state, 0);
        unlock_doors   = 1'b0;
        accelerate_car = 1'b0;
        step(1);    // e1682
        check("doors_relock", doors_unlocked, 0);

        accelerate_car = 1'b1;
        step(1);    // e1683
        check("en_accel", drv_state, 1);
        step(52);   // e1735, divider count now 5
        check("en_speed10", car_speed, 10);
        enable = 1'b0;
        step(50);
        check("frozen_speed", car_speed, 10);
        enable = 1'b1;
        step(4);
        check("resume_no_tick", car_speed, 10);
        step(1);
        check("resume_tick", car_speed, 12);
        step(140);
        check("pre_reset_40", car_speed, 40);

        #2 rst_n = 1'b0;
        #1;
        check("async_speed", car_speed, 0);
        check("async_state", drv_state, 0);
        check("async_doors", doors_unlocked, 0);
        check("async_moving", moving, 0);

`ifdef OVERSPEED_FLAG_EN
        @(negedge clk);
        rst_n = 1'b1;
        speed_limit = 8'd60;
        step(301);
        check("lim_speed60", car_speed, 60);
        check("lim_hold", drv_state, 2);
        check("lim_ovs0", overspeed, 0);
        speed_limit = 8'd50;
        step(1);    // e302
        check("lim_ovs1", overspeed, 1);
        check("lim_keep60", car_speed, 60);
        accelerate_car = 1'b0;
        step(1);    // e303
        check("lim_brake", drv_state, 3);
        step(7);    // e310
        check("lim_speed56", car_speed, 56);
        check("lim_ovs_still", overspeed, 1);
        step(20);   // e330
        check("lim_speed48", car_speed, 48);
        check("lim_ovs_clear", overspeed, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/drive_actuator.md
Name: drive_actuator

Overview:
Vehicle drive/plant-side block that consumes the cruise control unit's `accelerate_car` and `unlock_doors` commands. It produces the `car_speed` value fed back to that controller. It models a rate-limited drive train (accelerate/brake ramps on a divided tick) and a door-lock interlock that only releases doors once the car has been stationary for a hold time. It sits between the control FSM and the speed feedback path.

Parameters:
- SPEED_W, 8, width of car_speed
- MAX_SPEED, 200, speed saturation ceiling
- ACC_STEP, 2, speed increment per tick in ACCEL
- DEC_STEP, 4, speed decrement per tick in BRAKE
- TICK_DIV, 10, clock cycles per speed-update tick (>=2)
- DOOR_HOLD, 3, ticks at zero speed in PARKED before doors may unlock

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  1 = tick divider runs; 0 = divider and speed frozen
- accelerate_car  input  1  command from control unit, 1 = drive forward
- unlock_doors  input  1  door-unlock request from control unit
- car_speed  output  SPEED_W  current modeled speed, registered
- doors_unlocked  output  1  registered door state, 1 = unlocked
- moving  output  1  registered, 1 when car_speed != 0
- drv_state  output  2  current state: PARKED=00, ACCEL=01, HOLD=10, BRAKE=11

Behaviour:
- Reset (rst_n=0, async): car_speed=0, doors_unlocked=0, moving=0, drv_state=PARKED, tick counter=0, hold counter=0.
- Tick divider:
  - counts 0..TICK_DIV-1 while enable=1 and wraps to 0.
  - tick=1 for exactly the cycle where count==TICK_DIV-1 and enable=1.
  - enable=0 holds the count and suppresses tick.
- State transitions are evaluated every clock. Speed changes only on a tick edge.
- PARKED:
  - car_speed stays 0.
  - If accelerate_car=1 and unlock_doors=0 and doors_unlocked=0, go to ACCEL.
  - Otherwise stay.
  - doors_unlocked=1 blocks leaving PARKED.
- ACCEL:
  - On tick, car_speed = min(car_speed+ACC_STEP, MAX_SPEED). Compute in SPEED_W+1 bits, then clamp.
  - If accelerate_car=0 or unlock_doors=1, go to BRAKE. Unlocking while moving is a safety brake.
  - If car_speed==MAX_SPEED and accelerate_car=1, go to HOLD.
- HOLD:
  - Speed unchanged.
  - If accelerate_car=0 or unlock_doors=1, go to BRAKE.
- BRAKE:
  - On tick, car_speed = max(car_speed-DEC_STEP, 0), floored at 0 without wrap.
  - When car_speed==0, go to PARKED. This applies on the edge after the speed reaches 0, and also directly if BRAKE is entered at 0.
  - Else if accelerate_car=1 and unlock_doors=0, go to ACCEL. The zero check has priority.
- Door interlock:
  - The hold counter clears on any non-PARKED state, or when unlock_doors=0.
  - In PARKED with unlock_doors=1, the hold counter increments per tick and saturates at DOOR_HOLD.
  - doors_unlocked sets on the clock after the hold counter reaches DOOR_HOLD.
  - doors_unlocked clears on the first clock edge where unlock_doors=0.
  - doors_unlocked is never 1 while moving=1.
- moving = registered (next car_speed != 0); it updates on the same edge as car_speed.
- Simultaneous tick and state change: the speed update uses the current state; the new state affects the next tick only.
- MAX_SPEED not a multiple of ACC_STEP: clamp exactly to MAX_SPEED.

Optional Feature:
- Macro: OVERSPEED_FLAG_EN.
- When defined:
  - adds input speed_limit [SPEED_W-1:0] and output overspeed (registered);
  - in ACCEL the increment clamps to min(MAX_SPEED, speed_limit), and the HOLD condition uses that clamp value;
  - overspeed=1 whenever car_speed > speed_limit, e.g. when speed_limit is lowered mid-drive; reset value 0.
- When undefined: neither port exists and only MAX_SPEED clamps.

Test Plan:
- Reset mid-ACCEL at car_speed=40 -> asynchronously car_speed=0, drv_state=00, doors_unlocked=0, with no clock needed.
- Defaults, accelerate_car=1, unlock_doors=0 from PARKED -> drv_state=01 next clock; car_speed 2,4,6 on successive ticks (every 10 clocks); after 100 ticks car_speed=200 and drv_state=10.
- In HOLD at 200, drop accelerate_car -> BRAKE; speed decrements by 4 per tick; 0 after 50 ticks; then PARKED with moving=0.
- At car_speed=20 in ACCEL, assert unlock_doors=1 with accelerate_car=1 -> BRAKE; doors_unlocked stays 0 while moving; speed reaches 0 after 5 ticks; doors_unlocked=1 only after 3 more ticks in PARKED.
- enable=0 for 50 clocks during ACCEL at speed 10 -> car_speed stays 10 and the divider count is held; the next tick arrives at the remaining count on resume.
- OVERSPEED_FLAG_EN, speed_limit=60, accelerate -> speed clamps at 60 in HOLD; lower speed_limit to 50 -> overspeed=1 next clock; braking to 50 -> overspeed=0.
